// File: rtl/mac_accumulator.sv
// mac_accumulator: sums NTERMS unsigned 8-bit products taken over a
// valid/ready input and presents the total on a valid/ready result port.
// Build option: define SATURATE_EN to clamp the sum at all-ones on carry-out
// instead of wrapping; ovf is flagged in both builds.
module mac_accumulator #(
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned NTERMS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic [7:0]       prod_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             ovf
);

  localparam int unsigned CNT_W = $clog2(NTERMS + 1);
  localparam int unsigned SUM_W = ACC_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic [SUM_W-1:0]   sum;
  logic               carry;
  logic               accept;
  logic [ACC_W-1:0]   acc_next;

  // Adder: one extra bit so the carry-out can be observed
  always_comb begin
    sum   = {1'b0, acc_q} + SUM_W'(prod_in);
    carry = sum[ACC_W];
`ifdef SATURATE_EN
    acc_next = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    acc_next = sum[ACC_W-1:0];
`endif
  end

  assign accept = in_valid && (state_q == S_ACCUM);

  // Next-state and datapath update; clear takes priority over everything
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear) begin
      state_d = S_IDLE;
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_ACCUM;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
          end
        end
        S_ACCUM: begin
          if (accept) begin
            acc_d   = acc_next;
            count_d = count_q + CNT_W'(1);
            ovf_d   = ovf_q | carry;
            if (count_q == CNT_W'(NTERMS - 1)) begin
              state_d = S_DONE;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake flags decode the current state
  always_comb begin
    in_ready  = (state_q == S_ACCUM);
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
  end

  assign acc_out = acc_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: one instance with NTERMS=4/ACC_W=16 and
// one with NTERMS=8/ACC_W=10 share stimulus; each test begins with clear.
module tb_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, clear, in_valid, out_ready;
  logic [7:0]  prod_in;

  logic        in_ready4, out_valid4, busy4, ovf4;
  logic [15:0] acc4;
  logic        in_ready8, out_valid8, busy8, ovf8;
  logic [9:0]  acc8;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  mac_accumulator #(.ACC_W(16), .NTERMS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .prod_in(prod_in), .in_valid(in_valid), .in_ready(in_ready4),
    .acc_out(acc4), .out_valid(out_valid4), .out_ready(out_ready),
    .busy(busy4), .ovf(ovf4)
  );

  mac_accumulator #(.ACC_W(10), .NTERMS(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .prod_in(prod_in), .in_valid(in_valid), .in_ready(in_ready8),
    .acc_out(acc8), .out_valid(out_valid8), .out_ready(out_ready),
    .busy(busy8), .ovf(ovf8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input logic [7:0] p);
    in_valid = 1'b1;
    prod_in  = p;
    tick();
    in_valid = 1'b0;
  endtask

  logic [31:0] exp_sat;

  initial begin
    rst_n = 1'b0; start = 1'b0; clear = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; prod_in = 8'd0;
`ifdef SATURATE_EN
    exp_sat = 32'd1023;
`else
    exp_sat = 32'd1016;
`endif

    // Reset state
    #12;
    chk("rst_acc", 32'(acc4), 32'd0);
    chk("rst_busy", 32'(busy4), 32'd0);
    chk("rst_in_ready", 32'(in_ready4), 32'd0);
    chk("rst_out_valid", 32'(out_valid4), 32'd0);
    chk("rst_ovf", 32'(ovf4), 32'd0);
    rst_n = 1'b1;
    tick();

    // Test 1: four back-to-back 225s -> 900
    do_clear();
    do_start();
    chk("t1_in_ready", 32'(in_ready4), 32'd1);
    in_valid = 1'b1; prod_in = 8'd225;
    for (int i = 0; i < 3; i++) tick();
    chk("t1_ov_early", 32'(out_valid4), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("t1_out_valid", 32'(out_valid4), 32'd1);
    chk("t1_acc", 32'(acc4), 32'd900);
    chk("t1_ovf", 32'(ovf4), 32'd0);
    chk("t1_in_ready_done", 32'(in_ready4), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t1_ov_drop", 32'(out_valid4), 32'd0);
    chk("t1_busy_drop", 32'(busy4), 32'd0);

    // Test 2: eight 255s into 10-bit accumulator
    do_clear();
    do_start();
    in_valid = 1'b1; prod_in = 8'd255;
    for (int i = 0; i < 7; i++) tick();
    chk("t2_ov_early", 32'(out_valid8), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("t2_out_valid", 32'(out_valid8), 32'd1);
    chk("t2_acc", 32'(acc8), exp_sat);
    chk("t2_ovf", 32'(ovf8), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Test 3: in_valid every other cycle, stalled result port
    do_clear();
    do_start();
    for (int i = 0; i < 8; i++) begin
      in_valid = (i % 2 == 0);
      prod_in  = (i % 2 == 0) ? 8'(10 + i) : 8'd99;
      tick();
      if (i == 3) chk("t3_acc_mid", 32'(acc4), 32'd22);
    end
    chk("t3_acc", 32'(acc4), 32'd52);
    chk("t3_out_valid", 32'(out_valid4), 32'd1);
    in_valid = 1'b1; prod_in = 8'd200;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold_acc", 32'(acc4), 32'd52);
      chk("t3_hold_ov", 32'(out_valid4), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t3_idle_ov", 32'(out_valid4), 32'd0);
    chk("t3_idle_busy", 32'(busy4), 32'd0);
    chk("t3_idle_acc", 32'(acc4), 32'd52);

    // Test 4: clear mid-operation, then start+clear together
    do_clear();
    do_start();
    feed(8'd5);
    feed(8'd6);
    chk("t4_acc_part", 32'(acc4), 32'd11);
    do_clear();
    chk("t4_clr_busy", 32'(busy4), 32'd0);
    chk("t4_clr_acc", 32'(acc4), 32'd0);
    chk("t4_clr_ov", 32'(out_valid4), 32'd0);
    start = 1'b1; clear = 1'b1;
    tick();
    start = 1'b0; clear = 1'b0;
    chk("t4_sc_busy", 32'(busy4), 32'd0);
    in_valid = 1'b1; prod_in = 8'd77;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t4_idle_ov", 32'(out_valid4), 32'd0);
    end
    in_valid = 1'b0;
    chk("t4_idle_acc", 32'(acc4), 32'd0);
    chk("t4_idle_in_ready", 32'(in_ready4), 32'd0);

    // Test 5: asynchronous reset mid-ACCUM
    do_clear();
    do_start();
    feed(8'd200);
    feed(8'd255);
    feed(8'd255);
    feed(8'd255);
    feed(8'd255);
    chk("t5_pre_ovf8", 32'(ovf8), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_acc8", 32'(acc8), 32'd0);
    chk("t5_rst_busy8", 32'(busy8), 32'd0);
    chk("t5_rst_ovf8", 32'(ovf8), 32'd0);
    chk("t5_rst_in_ready8", 32'(in_ready8), 32'd0);
    chk("t5_rst_acc4", 32'(acc4), 32'd0);
    chk("t5_rst_ov4", 32'(out_valid4), 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    do_start();
    feed(8'd1);
    feed(8'd2);
    feed(8'd3);
    feed(8'd4);
    chk("t5_clean_acc", 32'(acc4), 32'd10);
    chk("t5_clean_ov", 32'(out_valid4), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Test 6: start pulses outside IDLE and products in IDLE/DONE ignored
    do_clear();
    do_start();
    feed(8'd1);
    start = 1'b1;
    feed(8'd2);
    start = 1'b0;
    chk("t6_acc_start_accum", 32'(acc4), 32'd3);
    chk("t6_busy_accum", 32'(busy4), 32'd1);
    feed(8'd3);
    feed(8'd4);
    chk("t6_acc_done", 32'(acc4), 32'd10);
    start = 1'b1;
    feed(8'd9);
    start = 1'b0;
    chk("t6_acc_start_done", 32'(acc4), 32'd10);
    chk("t6_ov_start_done", 32'(out_valid4), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    feed(8'd50);
    feed(8'd60);
    chk("t6_idle_acc", 32'(acc4), 32'd10);
    chk("t6_idle_busy", 32'(busy4), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
